// File: rtl/tc_fp_pkg.sv
// Shared definitions for the tensor-core float datapath:
// format widths, exponent bias helper and the sequencer state encoding.
package tc_fp_pkg;

   localparam int E4M3_EXP  = 4;
   localparam int E4M3_FRAC = 3;
   localparam int E5M3_EXP  = 5;
   localparam int E5M3_FRAC = 3;
   localparam int E5M2_EXP  = 5;
   localparam int E5M2_FRAC = 2;

   function automatic int bias(input int exp_width);
      return (1 << (exp_width - 1)) - 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/precision_tran.sv
// Combinational float format converter: rebias exponent, resize fraction,
// flush subnormals, propagate Inf/NaN and flag invalid/overflow/underflow.
module precision_tran
   import tc_fp_pkg::*;
#(
   parameter int EXP_WIDTH_IN   = E4M3_EXP,
   parameter int FRAC_WIDTH_IN  = E4M3_FRAC,
   parameter int EXP_WIDTH_OUT  = E5M3_EXP,
   parameter int FRAC_WIDTH_OUT = E5M3_FRAC
) (
   input  logic [EXP_WIDTH_IN+FRAC_WIDTH_IN:0]   in_fp,
   output logic [EXP_WIDTH_OUT+FRAC_WIDTH_OUT:0] out_fp,
   output logic                                  invalid,
   output logic                                  overflow,
   output logic                                  underflow
);

   localparam int EI = EXP_WIDTH_IN;
   localparam int FI = FRAC_WIDTH_IN;
   localparam int EO = EXP_WIDTH_OUT;
   localparam int FO = FRAC_WIDTH_OUT;
   localparam logic [FO-1:0] QNAN_FRAC = FO'(1) << (FO - 1);

   logic          sign;
   logic [EI-1:0] exp_in;
   logic [FI-1:0] frac_in;
   logic [FO-1:0] frac_cv;
   int            exp_rb;

   assign sign    = in_fp[EI+FI];
   assign exp_in  = in_fp[EI+FI-1:FI];
   assign frac_in = in_fp[FI-1:0];

   // Widening pads low bits with zeros; narrowing truncates toward zero.
   generate
      if (FO > FI) begin : g_frac_ext
         assign frac_cv = {frac_in, {(FO-FI){1'b0}}};
      end else if (FO == FI) begin : g_frac_eq
         assign frac_cv = frac_in;
      end else begin : g_frac_trunc
         assign frac_cv = frac_in[FI-1 -: FO];
      end
   endgenerate

   always_comb begin
      out_fp    = '0;
      invalid   = 1'b0;
      overflow  = 1'b0;
      underflow = 1'b0;
      exp_rb    = int'(exp_in) - bias(EI) + bias(EO);
      if (exp_in == {EI{1'b1}}) begin
         if (frac_in != '0) begin
            invalid = 1'b1;
            out_fp  = {sign, {EO{1'b1}}, QNAN_FRAC};
         end else begin
            out_fp  = {sign, {EO{1'b1}}, {FO{1'b0}}};
         end
      end else if (exp_in == '0) begin
         out_fp = {sign, {(EO+FO){1'b0}}};
      end else if (exp_rb >= (1 << EO) - 1) begin
         overflow = 1'b1;
         out_fp   = {sign, {EO{1'b1}}, {FO{1'b0}}};
      end else if (exp_rb <= 0) begin
         underflow = 1'b1;
         out_fp    = {sign, {(EO+FO){1'b0}}};
      end else begin
         out_fp = {sign, exp_rb[EO-1:0], frac_cv};
      end
   end

endmodule

// File: rtl/prec_conv_seq.sv
// Vector sequencer: latches a packed vector, pushes one element per cycle
// through a single shared precision_tran, and presents the assembled result.
module prec_conv_seq
   import tc_fp_pkg::*;
#(
   parameter int EXP_WIDTH_IN   = E4M3_EXP,
   parameter int FRAC_WIDTH_IN  = E4M3_FRAC,
   parameter int EXP_WIDTH_OUT  = E5M3_EXP,
   parameter int FRAC_WIDTH_OUT = E5M3_FRAC,
   parameter int NUM_ELEM       = 8,
   localparam int EW_IN  = EXP_WIDTH_IN + FRAC_WIDTH_IN + 1,
   localparam int EW_OUT = EXP_WIDTH_OUT + FRAC_WIDTH_OUT + 1,
   localparam int IDX_W  = $clog2(NUM_ELEM)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_ELEM*EW_IN-1:0]  in_vec,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_ELEM*EW_OUT-1:0] out_vec,
   output logic                       out_invalid,
   output logic                       out_overflow,
   output logic                       out_underflow,
   output logic [IDX_W:0]             out_nan_cnt,
   output logic                       busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [NUM_ELEM*EW_IN-1:0]  in_buf_q, in_buf_d;
   logic [NUM_ELEM*EW_OUT-1:0] out_buf_q, out_buf_d;
   logic                       inv_q, inv_d;
   logic                       ovf_q, ovf_d;
   logic                       unf_q, unf_d;
   logic [IDX_W:0]             nan_cnt_q, nan_cnt_d;

   logic [EW_IN-1:0]           cv_in;
   logic [EW_OUT-1:0]          cv_out;
   logic                       cv_inv, cv_ovf, cv_unf;

   assign cv_in = in_buf_q[idx_q*EW_IN +: EW_IN];

   precision_tran #(
      .EXP_WIDTH_IN   (EXP_WIDTH_IN),
      .FRAC_WIDTH_IN  (FRAC_WIDTH_IN),
      .EXP_WIDTH_OUT  (EXP_WIDTH_OUT),
      .FRAC_WIDTH_OUT (FRAC_WIDTH_OUT)
   ) u_conv (
      .in_fp     (cv_in),
      .out_fp    (cv_out),
      .invalid   (cv_inv),
      .overflow  (cv_ovf),
      .underflow (cv_unf)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      in_buf_d  = in_buf_q;
      out_buf_d = out_buf_q;
      inv_d     = inv_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      nan_cnt_d = nan_cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = CONV;
               idx_d     = '0;
               in_buf_d  = in_vec;
               out_buf_d = '0;
               inv_d     = 1'b0;
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               nan_cnt_d = '0;
            end
         end
         CONV: begin
            out_buf_d[idx_q*EW_OUT +: EW_OUT] = cv_out;
            inv_d     = inv_q | cv_inv;
            ovf_d     = ovf_q | cv_ovf;
            unf_d     = unf_q | cv_unf;
            nan_cnt_d = nan_cnt_q + {{IDX_W{1'b0}}, cv_inv};
            // idx parks on the last slot so it never wraps.
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         in_buf_q  <= '0;
         out_buf_q <= '0;
         inv_q     <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         nan_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         in_buf_q  <= in_buf_d;
         out_buf_q <= out_buf_d;
         inv_q     <= inv_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         nan_cnt_q <= nan_cnt_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign out_vec       = out_buf_q;
   assign out_invalid   = inv_q;
   assign out_overflow  = ovf_q;
   assign out_underflow = unf_q;
   assign out_nan_cnt   = nan_cnt_q;

endmodule

// File: tb/tb_prec_conv_seq.sv
// Directed bench for prec_conv_seq: E4M3 -> E5M3 vectors with hand-computed results.
module tb_prec_conv_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_vec;
   logic        out_valid;
   logic        out_ready;
   logic [71:0] out_vec;
   logic        out_invalid;
   logic        out_overflow;
   logic        out_underflow;
   logic [3:0]  out_nan_cnt;
   logic        busy;

   int checks_cnt = 0;
   int errors_cnt = 0;

   localparam logic [63:0] VEC_ONE   = 64'h3838_3838_3838_3838;
   localparam logic [63:0] VEC_MIXED = 64'h40FF_0001_787F_B838;
   localparam logic [63:0] VEC_NEG   = 64'hB8B8_B8B8_B8B8_B8B8;
   localparam logic [63:0] VEC_TWO   = 64'h4040_4040_4040_4040;
   localparam logic [63:0] VEC_NAN   = 64'h7F7F_7F7F_7F7F_7F7F;
   localparam logic [71:0] EXP_ONE   = {8{9'h078}};
   localparam logic [71:0] EXP_NEG   = {8{9'h178}};
   localparam logic [71:0] EXP_TWO   = {8{9'h080}};
   localparam logic [71:0] EXP_MIXED = {9'h080, 9'h1FC, 9'h000, 9'h000,
                                        9'h0F8, 9'h0FC, 9'h178, 9'h078};

   prec_conv_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_vec        (in_vec),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_vec       (out_vec),
      .out_invalid   (out_invalid),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_nan_cnt   (out_nan_cnt),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      checks_cnt++;
      if (obs !== exp_v) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Inputs are driven and outputs sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input logic [63:0] v);
      int n;
      in_vec   = v;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_accept"}, 128'(n < 20), 128'(1'b1));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 128'(n), 128'(8));
      $display("vector %s: done after %0d cycles out_vec=%h inv=%0b ovf=%0b unf=%0b nan_cnt=%0d",
               tag, n, out_vec, out_invalid, out_overflow, out_underflow, out_nan_cnt);
   endtask

   initial begin
      logic [71:0] held_vec;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_out_vec", 128'(out_vec), 128'(72'h0));

      // Single vector of +1.0
      send("ones", VEC_ONE);
      chk("ones_busy", 128'(busy), 128'(1'b1));
      chk("ones_in_ready", 128'(in_ready), 128'(1'b0));
      wait_out("ones");
      chk("ones_vec", 128'(out_vec), 128'(EXP_ONE));
      chk("ones_flags", 128'({out_invalid, out_overflow, out_underflow}), 128'(3'b000));
      chk("ones_nan", 128'(out_nan_cnt), 128'(4'd0));
      tick();
      chk("ones_ret_idle", 128'(in_ready), 128'(1'b1));
      chk("ones_ret_ov", 128'(out_valid), 128'(1'b0));

      // Mixed specials
      send("mixed", VEC_MIXED);
      wait_out("mixed");
      chk("mixed_vec", 128'(out_vec), 128'(EXP_MIXED));
      chk("mixed_inv", 128'(out_invalid), 128'(1'b1));
      chk("mixed_ovf", 128'(out_overflow), 128'(1'b0));
      chk("mixed_nan", 128'(out_nan_cnt), 128'(4'd2));
      tick();

      // Backpressure in DONE, with a competing vector offered
      out_ready = 1'b0;
      send("bp", VEC_NEG);
      wait_out("bp");
      in_vec   = VEC_MIXED;
      in_valid = 1'b1;
      held_vec = out_vec;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_vec", 128'(out_vec), 128'(EXP_NEG));
         chk("bp_hold_ov", 128'(out_valid), 128'(1'b1));
         chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
         chk("bp_flags", 128'({out_invalid, out_nan_cnt}), 128'({1'b0, 4'd0}));
      end
      chk("bp_held_vec", 128'(held_vec), 128'(EXP_NEG));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_rel_idle", 128'(in_ready), 128'(1'b1));
      chk("bp_rel_ov", 128'(out_valid), 128'(1'b0));
      send("bp_next", VEC_ONE);
      wait_out("bp_next");
      chk("bp_next_vec", 128'(out_vec), 128'(EXP_ONE));
      tick();

      // Back-to-back with in_valid held high
      in_vec   = VEC_MIXED;
      in_valid = 1'b1;
      tick();
      chk("b2b_acc1", 128'(busy), 128'(1'b1));
      in_vec = VEC_ONE;
      wait_out("b2b_first");
      chk("b2b_first_vec", 128'(out_vec), 128'(EXP_MIXED));
      chk("b2b_first_nan", 128'(out_nan_cnt), 128'(4'd2));
      chk("b2b_hs_in_ready", 128'(in_ready), 128'(1'b0));
      tick();
      chk("b2b_gap_in_ready", 128'(in_ready), 128'(1'b1));
      chk("b2b_gap_ov", 128'(out_valid), 128'(1'b0));
      tick();
      in_valid = 1'b0;
      chk("b2b_acc2", 128'(busy), 128'(1'b1));
      wait_out("b2b_second");
      chk("b2b_second_vec", 128'(out_vec), 128'(EXP_ONE));
      chk("b2b_second_inv", 128'(out_invalid), 128'(1'b0));
      chk("b2b_second_nan", 128'(out_nan_cnt), 128'(4'd0));
      tick();

      // Reset mid-conversion at idx 3
      send("rst_mid", VEC_ONE);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rmid_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rmid_ov", 128'(out_valid), 128'(1'b0));
      chk("rmid_busy", 128'(busy), 128'(1'b0));
      chk("rmid_vec", 128'(out_vec), 128'(72'h0));
      chk("rmid_nan", 128'(out_nan_cnt), 128'(4'd0));
      send("after_rst", VEC_MIXED);
      wait_out("after_rst");
      chk("arst_vec", 128'(out_vec), 128'(EXP_MIXED));
      chk("arst_nan", 128'(out_nan_cnt), 128'(4'd2));
      tick();

      // in_vec changed during conversion
      send("buffered", VEC_TWO);
      in_vec = VEC_NAN;
      wait_out("buffered");
      chk("buf_vec", 128'(out_vec), 128'(EXP_TWO));
      chk("buf_inv", 128'(out_invalid), 128'(1'b0));
      chk("buf_nan", 128'(out_nan_cnt), 128'(4'd0));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
